// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite palette arbiter and its flash FSMs.
package sprite_pkg;

    localparam int RGB_W = 12;
    localparam logic [RGB_W-1:0] RGB_WHITE = 12'hFFF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FLASH_ON  = 2'd1,
        FLASH_OFF = 2'd2
    } flash_state_e;

    // Transparent pixels always pass through so the mixer downstream can key them out.
    function automatic logic [RGB_W-1:0] pixel_colour(
        input logic [RGB_W-1:0] rgb,
        input logic             is_transparent,
        input logic             flash_on
    );
        logic [RGB_W-1:0] result;
        if (is_transparent) begin
            result = rgb;
        end else if (flash_on) begin
            result = RGB_WHITE;
        end else begin
            result = rgb;
        end
        return result;
    endfunction

endpackage

// File: rtl/hit_flash_fsm.sv
// Per-player hit flash: alternates white/normal every TOGGLE_FRAMES frames for FLASH_FRAMES frames.
module hit_flash_fsm
    import sprite_pkg::*;
#(
    parameter int FLASH_FRAMES  = 8,
    parameter int TOGGLE_FRAMES = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_start,
    input  logic hit,
    output logic flash_on
);

    localparam logic [7:0] FRAME_LOAD = 8'(FLASH_FRAMES);
    localparam logic [7:0] PHASE_LOAD = 8'(TOGGLE_FRAMES);

    flash_state_e state_q;
    logic [7:0]   frame_q;
    logic [7:0]   phase_q;
    logic [7:0]   frame_dec_d;
    logic [7:0]   phase_dec_d;

    // Decremented counter values used when a frame boundary is counted.
    always_comb begin
        frame_dec_d = frame_q - 8'd1;
        phase_dec_d = phase_q - 8'd1;
    end

    // Flash state machine; a hit wins over a simultaneous frame_start.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            frame_q <= 8'd0;
            phase_q <= 8'd0;
        end else if (hit) begin
            state_q <= FLASH_ON;
            frame_q <= FRAME_LOAD;
            phase_q <= PHASE_LOAD;
        end else if (frame_start) begin
            case (state_q)
                FLASH_ON, FLASH_OFF: begin
                    if (frame_dec_d == 8'd0) begin
                        state_q <= IDLE;
                        frame_q <= 8'd0;
                        phase_q <= 8'd0;
                    end else if (phase_dec_d == 8'd0) begin
                        state_q <= (state_q == FLASH_ON) ? FLASH_OFF : FLASH_ON;
                        frame_q <= frame_dec_d;
                        phase_q <= PHASE_LOAD;
                    end else begin
                        state_q <= state_q;
                        frame_q <= frame_dec_d;
                        phase_q <= phase_dec_d;
                    end
                end
                IDLE: begin
                    state_q <= IDLE;
                    frame_q <= frame_q;
                    phase_q <= phase_q;
                end
                default: begin
                    state_q <= IDLE;
                    frame_q <= 8'd0;
                    phase_q <= 8'd0;
                end
            endcase
        end else begin
            state_q <= state_q;
            frame_q <= frame_q;
            phase_q <= phase_q;
        end
    end

    assign flash_on = (state_q == FLASH_ON);

endmodule

// File: rtl/sprite_palette_arbiter.sv
// Round-robin share of one combinational palette between two sprite renderers,
// with per-player hit flash applied to the registered pixel colour.
module sprite_palette_arbiter
    import sprite_pkg::*;
#(
    parameter int         FLASH_FRAMES    = 8,
    parameter int         TOGGLE_FRAMES   = 2,
    parameter logic [3:0] TRANSPARENT_IDX = 4'hF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_start,
    input  logic [1:0]       req,
    input  logic [3:0]       index_p1,
    input  logic [3:0]       index_p2,
    input  logic             hit_p1,
    input  logic             hit_p2,
    output logic [1:0]       gnt,
    output logic [3:0]       pal_index,
    input  logic [RGB_W-1:0] pal_rgb,
    output logic             rgb_valid,
    output logic             rgb_id,
    output logic             transparent,
    output logic [3:0]       red,
    output logic [3:0]       green,
    output logic [3:0]       blue
);

    logic             last_p2_q;
    logic             valid_q;
    logic             id_q;
    logic             transp_q;
    logic [RGB_W-1:0] rgb_q;

    logic [1:0]       gnt_s;
    logic [3:0]       index_s;
    logic             sel_flash_s;
    logic             sel_transp_s;
    logic             p1_flash_on_s;
    logic             p2_flash_on_s;

    hit_flash_fsm #(
        .FLASH_FRAMES (FLASH_FRAMES),
        .TOGGLE_FRAMES(TOGGLE_FRAMES)
    ) u_flash_p1 (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_start(frame_start),
        .hit        (hit_p1),
        .flash_on   (p1_flash_on_s)
    );

    hit_flash_fsm #(
        .FLASH_FRAMES (FLASH_FRAMES),
        .TOGGLE_FRAMES(TOGGLE_FRAMES)
    ) u_flash_p2 (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_start(frame_start),
        .hit        (hit_p2),
        .flash_on   (p2_flash_on_s)
    );

    // Grant and palette index; last_p2_q resets high so P1 wins the first contention.
    always_comb begin
        gnt_s        = 2'b00;
        index_s      = 4'h0;
        sel_flash_s  = 1'b0;
        sel_transp_s = 1'b0;
        if (Reset) begin
            gnt_s = 2'b00;
        end else begin
            case (req)
                2'b01:   gnt_s = 2'b01;
                2'b10:   gnt_s = 2'b10;
                2'b11:   gnt_s = last_p2_q ? 2'b01 : 2'b10;
                default: gnt_s = 2'b00;
            endcase
        end
        if (gnt_s[0]) begin
            index_s     = index_p1;
            sel_flash_s = p1_flash_on_s;
        end else if (gnt_s[1]) begin
            index_s     = index_p2;
            sel_flash_s = p2_flash_on_s;
        end else begin
            index_s     = 4'h0;
            sel_flash_s = 1'b0;
        end
        sel_transp_s = (gnt_s != 2'b00) && (index_s == TRANSPARENT_IDX);
    end

    // Round-robin history and registered pixel result.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            last_p2_q <= 1'b1;
            valid_q   <= 1'b0;
            id_q      <= 1'b0;
            transp_q  <= 1'b0;
            rgb_q     <= {RGB_W{1'b0}};
        end else if (gnt_s != 2'b00) begin
            last_p2_q <= gnt_s[1];
            valid_q   <= 1'b1;
            id_q      <= gnt_s[1];
            transp_q  <= sel_transp_s;
            rgb_q     <= pixel_colour(pal_rgb, sel_transp_s, sel_flash_s);
        end else begin
            last_p2_q <= last_p2_q;
            valid_q   <= 1'b0;
            id_q      <= 1'b0;
            transp_q  <= 1'b0;
            rgb_q     <= {RGB_W{1'b0}};
        end
    end

    assign gnt         = gnt_s;
    assign pal_index   = index_s;
    assign rgb_valid   = valid_q;
    assign rgb_id      = id_q;
    assign transparent = transp_q;
    assign red         = rgb_q[11:8];
    assign green       = rgb_q[7:4];
    assign blue        = rgb_q[3:0];

endmodule
